// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pipe
//  Purpose  : Parametrised pipelined add/subtract unit. The WIDTH-bit carry
//             chain is cut into STAGES equal slices with one register stage
//             per slice. Provides add/sub select, raw carry-out, two's-
//             complement overflow and valid/ready handshakes on both sides.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             in_valid / in_ready  - operand handshake (in_ready = advance)
//             a, b, cin, sub       - operands, carry/borrow-in, mode select
//             out_valid/out_ready  - result handshake
//             sum, cout, ovf       - registered result, carry-out, overflow
//  Revision : 1.0  initial release
// ============================================================================
module adder_pipe #(
    parameter int WIDTH  = 8,   // >= 2
    parameter int STAGES = 2    // divides WIDTH, 1..WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_SL = WIDTH / STAGES;   // bits per carry slice

    // Per-stage registers. Operands travel with the beat in full width so
    // each stage can pick its own slice; the partial sum fills slice by slice.
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];   // effective (possibly inverted) b
    logic [WIDTH-1:0]  r_s [STAGES];
    logic              r_ovf;

    // Stage inputs and next-state values
    logic [WIDTH-1:0]  w_ain   [STAGES];
    logic [WIDTH-1:0]  w_bin   [STAGES];
    logic [WIDTH-1:0]  w_sin   [STAGES];
    logic [STAGES-1:0] w_cin;
    logic [STAGES-1:0] w_vin;
    logic [c_SL:0]     w_part  [STAGES];
    logic [WIDTH-1:0]  w_snext [STAGES];
    logic [STAGES-1:0] w_cnext;
    logic              w_ovf;
    logic              w_adv;

    // The whole pipe moves together; it only stalls when the output holds a
    // beat the sink has not taken yet.
    assign w_adv    = !r_vld[STAGES-1] || out_ready;
    assign in_ready = w_adv;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                // Subtraction is a + ~b + ~borrow; the inversion happens once
                // at capture so later stages are plain adders.
                assign w_ain[k] = a;
                assign w_bin[k] = sub ? ~b : b;
                assign w_sin[k] = '0;
                assign w_cin[k] = sub ? ~cin : cin;
                assign w_vin[k] = in_valid;
            end else begin : g_body
                assign w_ain[k] = r_a[k-1];
                assign w_bin[k] = r_b[k-1];
                assign w_sin[k] = r_s[k-1];
                assign w_cin[k] = r_c[k-1];
                assign w_vin[k] = r_vld[k-1];
            end
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_part[k]  = {1'b0, w_ain[k][k*c_SL +: c_SL]}
                       + {1'b0, w_bin[k][k*c_SL +: c_SL]}
                       + {{c_SL{1'b0}}, w_cin[k]};
            w_snext[k] = w_sin[k];
            w_snext[k][k*c_SL +: c_SL] = w_part[k][c_SL-1:0];
            w_cnext[k] = w_part[k][c_SL];
        end
        // Overflow only needs the sign bits, all available in the last stage
        w_ovf = (w_ain[STAGES-1][WIDTH-1] == w_bin[STAGES-1][WIDTH-1])
             && (w_snext[STAGES-1][WIDTH-1] != w_ain[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (w_adv) begin
            // Data registers load even for bubbles; the valid bit marks them.
            r_vld <= w_vin;
            r_c   <= w_cnext;
            r_ovf <= w_ovf;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= w_ain[k];
                r_b[k] <= w_bin[k];
                r_s[k] <= w_snext[k];
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_pipe
//  Purpose  : Self-checking bench for adder_pipe (WIDTH=8, STAGES=2):
//             directed vector table, random streaming with a reference
//             model, back-pressure stall and mid-flight reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_pipe;

    localparam int c_W = 8;

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic [c_W-1:0] a         = '0;
    logic [c_W-1:0] b         = '0;
    logic           cin       = 1'b0;
    logic           sub       = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [c_W-1:0] sum;
    logic           cout;
    logic           ovf;

    int checks = 0;
    int errors = 0;

    adder_pipe #(.WIDTH(c_W), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model from integer arithmetic: {cout, ovf, sum}
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci, input logic sb);
        int ua, ub, sa, sy, c, ures, sres;
        logic co, ov;
        ua = int'(x);
        ub = int'(y);
        sa = int'($signed(x));
        sy = int'($signed(y));
        c  = ci ? 1 : 0;
        if (sb) begin
            ures = ua - ub - c;
            sres = sa - sy - c;
            co   = (ures >= 0);          // carry out set when no borrow
        end else begin
            ures = ua + ub + c;
            sres = sa + sy + c;
            co   = (ures > 255);
        end
        ov = (sres > 127) || (sres < -128);
        return {co, ov, 8'(ures)};
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake
    logic [9:0] q [$];
    int n_out     = 0;
    int cyc       = 0;
    int first_out = -1;
    int last_out  = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got sum=%0h with no beat outstanding", sum);
                end else begin
                    chk("stream_result", 32'({cout, ovf, sum}), 32'(q.pop_front()));
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sb;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vt [7];

    task automatic stream(input int n, input int stall_at, input int stall_len);
        int sent = 0;
        int k    = 0;
        int j    = 0;
        int n0;
        logic loaded = 1'b0;
        logic [10:0] held = '0;
        n0 = n_out;
        first_out = -1;
        while (sent < n && k < n * 4 + 40) begin
            if (!loaded) begin
                {a, b, cin, sub} = 18'($urandom);
                in_valid = 1'b1;
                loaded   = 1'b1;
            end
            out_ready = !(k >= stall_at && k < stall_at + stall_len);
            @(negedge clk);
            if (stall_len > 0 && k == stall_at) begin
                held = {out_valid, cout, ovf, sum};
                chk("stall_valid", 32'(out_valid), 32'd1);
            end
            if (stall_len > 0 && k >= stall_at && k < stall_at + stall_len) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                if (k > stall_at)
                    chk("stall_hold", 32'({out_valid, cout, ovf, sum}), 32'(held));
            end
            if (in_valid && in_ready) begin
                sent++;
                loaded = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", 32'(sent), 32'(n));
        while ((n_out - n0) < n && j < 20) begin
            @(posedge clk);
            #1;
            j++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("beats_out", 32'(n_out - n0), 32'(n));
        chk("queue_empty", 32'(q.size()), 32'd0);
        if (stall_len == 0)
            chk("throughput", 32'(last_out - first_out), 32'(n - 1));
    endtask

    initial begin
        int n;
        int n0;

        vt[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vt[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vt[5] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0};
        vt[6] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, one beat at a time, with latency measurement
        for (int i = 0; i < 7; i++) begin
            a = vt[i].a; b = vt[i].b; cin = vt[i].ci; sub = vt[i].sb;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            n = 0;
            do begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                n++;
            end while (!out_valid && n < 8);
            chk($sformatf("vec%0d_latency", i), 32'(n),    32'd2);
            chk($sformatf("vec%0d_sum", i),     32'(sum),  32'(vt[i].s));
            chk($sformatf("vec%0d_cout", i),    32'(cout), 32'(vt[i].co));
            chk($sformatf("vec%0d_ovf", i),     32'(ovf),  32'(vt[i].ov));
            @(posedge clk);
            #1;
        end

        // Back-to-back random stream, then a stream with a 5-cycle stall
        stream(16, 0, 0);
        stream(20, 6, 5);

        // Reset with two beats in flight: neither may ever appear
        out_ready = 1'b0;
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h56; b = 8'h78;
        @(posedge clk);
        #1;
        chk("inflight_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        n0 = n_out;
        @(posedge clk);
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_sum",       32'(sum),       32'd0);
        chk("flush_cout",      32'(cout),      32'd0);
        chk("flush_ovf",       32'(ovf),       32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("flush_no_emit", 32'(n_out - n0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
